// File: rtl/jtcop_colmix_pkg.sv
// Shared types and helpers for the jtcop N-layer colour mixer.
// Palette-copy state encoding is used only when JTCOP_PALBUF_EN is defined.
package jtcop_colmix_pkg;

    typedef enum logic {
        CP_IDLE = 1'b0,
        CP_COPY = 1'b1
    } copy_state_e;

    localparam int COLW = 4;

    function automatic int calc_lw(input int layers);
        return (layers <= 2) ? 1 : $clog2(layers);
    endfunction

    function automatic logic [7:0] expand_nibble(input logic [COLW-1:0] n);
        return {n, n};
    endfunction

endpackage

// File: rtl/jtcop_palbuf_copy.sv
// Vertical-blank palette copy engine: walks every palette word once per frame,
// reading the shadow RAM and writing the live RAM one clk later.
module jtcop_palbuf_copy
    import jtcop_colmix_pkg::*;
#(
    parameter int AW = 10
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    output copy_state_e   state,
    output logic [AW-1:0] rd_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr
);

    logic lvbl_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CP_IDLE;
            lvbl_l  <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_en   <= 1'b0;
        end else begin
            lvbl_l <= LVBL;
            case (state)
                CP_IDLE: begin
                    wr_en <= 1'b0;
                    if (lvbl_l && !LVBL) begin
                        state   <= CP_COPY;
                        rd_addr <= '0;
                    end
                end
                CP_COPY: begin
                    // Writes trail reads by one clk to absorb the shadow read latency
                    rd_addr <= rd_addr + 1'b1;
                    wr_addr <= rd_addr;
                    wr_en   <= 1'b1;
                    if (wr_en && (&wr_addr)) begin
                        state   <= CP_IDLE;
                        wr_en   <= 1'b0;
                        rd_addr <= '0;
                    end
                end
                default: state <= CP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/jtcop_colmix_n.sv
// N-layer colour mixer: priority PROM, 16-bit palette, 4->8 bit BGR expansion.
// Define JTCOP_PALBUF_EN for a shadow palette copied to the live one in vblank.
module jtcop_colmix_n
    import jtcop_colmix_pkg::*;
#(
    parameter int LAYERS  = 4,
    parameter int PXLW    = 8,
    parameter int ATTRW   = 2,
    parameter int PRIO_AW = 10,
    parameter int PALW    = calc_lw(LAYERS) + PXLW,
    localparam int LW     = calc_lw(LAYERS)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic                   pal_cs,
    input  logic [PALW-1:0]        cpu_addr,
    input  logic [15:0]            cpu_dout,
    input  logic [1:0]             dsn,
    output logic [15:0]            cpu_din,
    input  logic [2:0]             prisel,
    input  logic [ATTRW-1:0]       prio_attr,
    input  logic [PRIO_AW-1:0]     prog_addr,
    input  logic [LW-1:0]          prom_din,
    input  logic                   prom_we,
    input  logic [LAYERS*PXLW-1:0] lyr_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    output logic [7:0]             red,
    output logic [7:0]             green,
    output logic [7:0]             blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    output logic                   busy
);

    logic [LW-1:0]          prom [0:2**PRIO_AW-1];
    logic [15:0]            pal_live [0:2**PALW-1];

    logic [LAYERS-1:0]      blank;
    logic [PRIO_AW-1:0]     prom_a;
    logic [PRIO_AW-1:0]     s1_addr;
    logic [LAYERS*PXLW-1:0] s1_pxl, s2_pxl;
    logic [LW-1:0]          s2_sel;
    logic [PALW-1:0]        s3_addr;
    logic [2:0]             hb_sr, vb_sr;

    always_comb begin
        blank = '0;
        for (int k = 0; k < LAYERS; k++)
            blank[k] = (lyr_pxl[k*PXLW +: COLW] == '0) || !gfx_en[k];
    end

    assign prom_a = PRIO_AW'({prisel, prio_attr, blank});

    always_ff @(posedge clk) begin
        if (prom_we) prom[prog_addr] <= prom_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr  <= '0;
            s1_pxl   <= '0;
            s2_sel   <= '0;
            s2_pxl   <= '0;
            s3_addr  <= '0;
            hb_sr    <= '0;
            vb_sr    <= '0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (pxl_cen) begin
            s1_addr  <= prom_a;
            s1_pxl   <= lyr_pxl;
            s2_sel   <= prom[s1_addr];
            s2_pxl   <= s1_pxl;
            s3_addr  <= PALW'({s2_sel, s2_pxl[s2_sel*PXLW +: PXLW]});
            hb_sr    <= {hb_sr[1:0], LHBL};
            vb_sr    <= {vb_sr[1:0], LVBL};
            LHBL_dly <= hb_sr[2];
            LVBL_dly <= vb_sr[2];
            if (hb_sr[2] && vb_sr[2]) begin
                red   <= expand_nibble(pal_live[s3_addr][3:0]);
                green <= expand_nibble(pal_live[s3_addr][7:4]);
                blue  <= expand_nibble(pal_live[s3_addr][11:8]);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

`ifdef JTCOP_PALBUF_EN
    logic [15:0]     pal_shadow [0:2**PALW-1];
    logic [15:0]     cp_q;
    logic [PALW-1:0] cp_ra, cp_wa;
    logic            cp_we;
    copy_state_e     cp_state;

    jtcop_palbuf_copy #(.AW(PALW)) u_copy (
        .clk     (clk),
        .rst_n   (rst_n),
        .LVBL    (LVBL),
        .state   (cp_state),
        .rd_addr (cp_ra),
        .wr_en   (cp_we),
        .wr_addr (cp_wa)
    );

    assign busy = (cp_state == CP_COPY);

    // CPU owns the shadow; the live copy is only touched by the copy engine
    always_ff @(posedge clk) begin
        if (pal_cs) begin
            if (!dsn[0]) pal_shadow[cpu_addr][7:0]  <= cpu_dout[7:0];
            if (!dsn[1]) pal_shadow[cpu_addr][15:8] <= cpu_dout[15:8];
        end
        cp_q <= pal_shadow[cp_ra];
        if (cp_we) pal_live[cp_wa] <= cp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cpu_din <= '0;
        else        cpu_din <= pal_shadow[cpu_addr];
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (pal_cs) begin
            if (!dsn[0]) pal_live[cpu_addr][7:0]  <= cpu_dout[7:0];
            if (!dsn[1]) pal_live[cpu_addr][15:8] <= cpu_dout[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cpu_din <= '0;
        else        cpu_din <= pal_live[cpu_addr];
    end
`endif

endmodule

// File: tb/tb_jtcop_colmix_n.sv
// Directed, table-driven bench for jtcop_colmix_n (LAYERS=4, PXLW=8, PALW=10).
// Buffer-copy scenarios are exercised when JTCOP_PALBUF_EN is defined.
module tb_jtcop_colmix_n;

  localparam int LAYERS  = 4;
  localparam int PXLW    = 8;
  localparam int ATTRW   = 2;
  localparam int PRIO_AW = 10;
  localparam int PALW    = 10;

  logic        clk, rst_n, pxl_cen, LHBL, LVBL, pal_cs, prom_we, busy;
  logic [9:0]  cpu_addr, prog_addr;
  logic [15:0] cpu_dout, cpu_din;
  logic [1:0]  dsn, prio_attr, prom_din;
  logic [2:0]  prisel;
  logic [31:0] lyr_pxl;
  logic [3:0]  gfx_en;
  logic [7:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pal_model [1024];
  logic [15:0] sh_model  [1024];

  typedef struct {
    logic [2:0]  ps;
    logic [1:0]  at;
    logic [31:0] px;
    logic [3:0]  ge;
    logic        hb;
    logic        vb;
    logic [23:0] exp_rgb;
  } vec_t;
  vec_t vecs [9];

  jtcop_colmix_n #(
    .LAYERS(LAYERS), .PXLW(PXLW), .ATTRW(ATTRW), .PRIO_AW(PRIO_AW), .PALW(PALW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .pal_cs(pal_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn),
    .cpu_din(cpu_din), .prisel(prisel), .prio_attr(prio_attr),
    .prog_addr(prog_addr), .prom_din(prom_din), .prom_we(prom_we),
    .lyr_pxl(lyr_pxl), .gfx_en(gfx_en), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference contents
  function automatic logic [1:0] prom_fn(input logic [9:0] a);
    logic [3:0] b;
    logic [1:0] r;
    logic       found;
    b = a[3:0];
    r = 2'd3;
    found = 1'b0;
    if (a == 10'h00A) r = 2'd2;
    else if (a[5:4] == 2'b11) r = 2'd1;
    else if (b == 4'hF) r = 2'd3;
    else if (a[6]) begin
      for (int k = 3; k >= 0; k--)
        if (!b[k] && !found) begin r = 2'(k); found = 1'b1; end
    end else begin
      for (int k = 0; k < 4; k++)
        if (!b[k] && !found) begin r = 2'(k); found = 1'b1; end
    end
    return r;
  endfunction

  function automatic logic [15:0] pal_fill(input int a);
    if (a == 'h225) return 16'h0ABC;
    if (a == 'h300) return 16'h0F00;
    return 16'(a * 37) ^ 16'hA5C3;
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [2:0] ps, input logic [1:0] at,
                                          input logic [31:0] px, input logic [3:0] ge);
    logic [3:0]  b;
    logic [1:0]  sel;
    logic [7:0]  pix;
    logic [15:0] w;
    for (int k = 0; k < 4; k++) b[k] = (px[k*8 +: 4] == 4'h0) || !ge[k];
    sel = prom_fn({1'b0, ps, at, b});
    pix = px[sel*8 +: 8];
    w   = pal_model[{sel, pix}];
    return {w[3:0], w[3:0], w[7:4], w[7:4], w[11:8], w[11:8]};
  endfunction

  // driver tasks
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    pxl_cen = 1'b1;
    clk_step();
    pxl_cen = 1'b0;
    clk_step();
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] ds);
    cpu_addr = a;
    cpu_dout = d;
    dsn      = ds;
    pal_cs   = 1'b1;
    clk_step();
    pal_cs   = 1'b0;
    dsn      = 2'b11;
    for (int i = 0; i < 2; i++)
      if (!ds[i]) sh_model[a][i*8 +: 8] = d[i*8 +: 8];
`ifndef JTCOP_PALBUF_EN
    pal_model[a] = sh_model[a];
`endif
  endtask

  task automatic prom_write(input logic [9:0] a, input logic [1:0] d);
    prog_addr = a;
    prom_din  = d;
    prom_we   = 1'b1;
    clk_step();
    prom_we   = 1'b0;
  endtask

  task automatic set_video(input logic [2:0] ps, input logic [1:0] at,
                           input logic [31:0] px, input logic [3:0] ge);
    prisel = ps; prio_attr = at; lyr_pxl = px; gfx_en = ge;
  endtask

  // drops LVBL and counts busy clk; optional second falling edge mid-copy
  task automatic run_copy(input int glitch_at, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    LVBL = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      clk_step();
      if (busy) begin seen = 1'b1; cnt++; end
      else if (seen) break;
      if (glitch_at > 0 && cnt == glitch_at)      LVBL = 1'b1;
      if (glitch_at > 0 && cnt == glitch_at + 50) LVBL = 1'b0;
    end
    LVBL = 1'b1;
    clk_step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      clk_step();
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    logic [23:0] old_rgb;

    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    pal_cs = 1'b0; cpu_addr = '0; cpu_dout = '0; dsn = 2'b11;
    prisel = '0; prio_attr = '0; prog_addr = '0; prom_din = '0; prom_we = 1'b0;
    lyr_pxl = '0; gfx_en = 4'hF;
    repeat (3) clk_step();
    check("reset_rgb", {red, green, blue}, 24'h0);
    check("reset_blank_dly", {LHBL_dly, LVBL_dly}, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_cpu_din", cpu_din, 16'h0);
    rst_n = 1'b1;
    clk_step();

    for (int a = 0; a < 1024; a++) prom_write(10'(a), prom_fn(10'(a)));
    for (int a = 0; a < 1024; a++) begin
      pal_model[a] = pal_fill(a);
      sh_model[a]  = pal_model[a];
      cpu_write(10'(a), pal_model[a], 2'b00);
    end
`ifdef JTCOP_PALBUF_EN
    run_copy(0, cnt);
    check("init_copy_len", cnt, 1025);
    pal_model = sh_model;
`endif

    vecs[0] = '{3'd0, 2'd0, 32'h0025_0013, 4'hF,    1'b1, 1'b1, 24'hCCBBAA};
    vecs[1] = '{3'd0, 2'd0, 32'h0000_0000, 4'hF,    1'b1, 1'b1, 24'h0000FF};
    vecs[2] = '{3'd0, 2'd0, 32'h0025_0013, 4'b1011, 1'b1, 1'b1, 24'h0};
    vecs[3] = '{3'd0, 2'd0, 32'h9A00_4713, 4'hF,    1'b1, 1'b1, 24'h0};
    vecs[4] = '{3'd1, 2'd0, 32'h9A00_4713, 4'hF,    1'b1, 1'b1, 24'h0};
    vecs[5] = '{3'd0, 2'd3, 32'h9A00_4713, 4'hF,    1'b1, 1'b1, 24'h0};
    vecs[6] = '{3'd0, 2'd0, 32'h0000_22F0, 4'hF,    1'b1, 1'b1, 24'h0};
    vecs[7] = '{3'd0, 2'd0, 32'h0025_0013, 4'hF,    1'b0, 1'b1, 24'h0};
    vecs[8] = '{3'd0, 2'd0, 32'h0025_0013, 4'hF,    1'b1, 1'b0, 24'h0};
    for (int i = 2; i <= 6; i++)
      vecs[i].exp_rgb = exp_rgb(vecs[i].ps, vecs[i].at, vecs[i].px, vecs[i].ge);

    for (int i = 0; i < 9; i++) begin
      set_video(vecs[i].ps, vecs[i].at, vecs[i].px, vecs[i].ge);
      LHBL = vecs[i].hb;
      LVBL = vecs[i].vb;
      repeat (5) tick();
      check($sformatf("vec%0d_rgb", i), {red, green, blue}, vecs[i].exp_rgb);
      check($sformatf("vec%0d_blank", i), {LHBL_dly, LVBL_dly}, {vecs[i].hb, vecs[i].vb});
    end
    LHBL = 1'b1;
    LVBL = 1'b1;
    wait_idle();

    // 4-tick latency: backdrop holds for three ticks after the change
    set_video(3'd0, 2'd0, 32'h0, 4'hF);
    repeat (5) tick();
    set_video(3'd0, 2'd0, 32'h0025_0013, 4'hF);
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("latency_hold%0d", t), {red, green, blue}, 24'h0000FF);
    end
    tick();
    check("latency_4", {red, green, blue}, 24'hCCBBAA);

    // one-pixel horizontal blank
    LHBL = 1'b0;
    tick();
    LHBL = 1'b1;
    tick();
    tick();
    check("hblank_pre", LHBL_dly, 1'b1);
    tick();
    check("hblank_dly", LHBL_dly, 1'b0);
    check("hblank_rgb", {red, green, blue}, 24'h0);
    tick();
    check("hblank_post_dly", LHBL_dly, 1'b1);
    check("hblank_post_rgb", {red, green, blue}, 24'hCCBBAA);

    // CPU read path and byte strobes
    cpu_addr = 10'h225;
    clk_step();
    check("cpu_read", cpu_din, 16'h0ABC);
    cpu_write(10'h010, 16'hFFEE, 2'b10);
    cpu_write(10'h010, 16'h7711, 2'b01);
    clk_step();
    check("cpu_byte_write", cpu_din, {8'h77, 8'hEE});

    // palette word 5 update seen through layer 0
    set_video(3'd0, 2'd0, 32'h0000_0005, 4'hF);
    repeat (5) tick();
    old_rgb = {red, green, blue};
    check("word5_before", old_rgb, exp_rgb(3'd0, 2'd0, 32'h5, 4'hF));
    cpu_write(10'h005, 16'h0123, 2'b00);
    repeat (5) tick();
`ifdef JTCOP_PALBUF_EN
    check("word5_shadow_only", {red, green, blue}, old_rgb);
    run_copy(400, cnt);
    check("copy_len_no_restart", cnt, 1025);
    pal_model = sh_model;
    repeat (5) tick();
`else
    run_copy(0, cnt);
    check("busy_tied_low", cnt, 0);
`endif
    check("word5_after", {red, green, blue}, 24'h332211);

    // reset with video running: outputs clear, memories survive
    rst_n = 1'b0;
    #1;
    check("rst_rgb", {red, green, blue}, 24'h0);
    clk_step();
    rst_n = 1'b1;
    clk_step();
    repeat (5) tick();
    check("rst_retained", {red, green, blue}, 24'h332211);

`ifdef JTCOP_PALBUF_EN
    // reset mid-copy leaves the live palette partially updated
    cpu_write(10'h300, 16'h00F0, 2'b00);
    set_video(3'd0, 2'd0, 32'h0, 4'hF);
    repeat (5) tick();
    check("midrst_pre", {red, green, blue}, 24'h0000FF);
    cnt  = 0;
    LVBL = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      clk_step();
      if (busy) cnt++;
      if (cnt == 300) break;
    end
    check("midrst_reached", cnt, 300);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rgb", {red, green, blue}, 24'h0);
    LVBL = 1'b1;
    repeat (2) clk_step();
    rst_n = 1'b1;
    clk_step();
    repeat (5) tick();
    check("midrst_partial", {red, green, blue}, 24'h0000FF);
    run_copy(0, cnt);
    check("midrst_recopy_len", cnt, 1025);
    pal_model = sh_model;
    repeat (5) tick();
    check("midrst_recopy", {red, green, blue}, 24'h00FF00);
`else
    cpu_write(10'h300, 16'h00F0, 2'b00);
    set_video(3'd0, 2'd0, 32'h0, 4'hF);
    repeat (5) tick();
    check("direct_write_backdrop", {red, green, blue}, 24'h00FF00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
